serial_pattern_gen: RTL and testbench

- Serial bit-stream transmitter. Loads a pattern word and shifts it out one bit per clock, MSB of the active field first, with a valid qualifier.
- Optional repetition with inter-frame gaps.
- The transmit-side counterpart of the team's serial sequence-detector FSMs. Drives their single-bit input stream in system and on benches.

---
 rtl/serial_pattern_gen.sv | 191 +++++++++++++++++++
 tb/tb_serial_pattern_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: shifts a latched pattern out MSB-first with valid, optional repeats and gaps.
// Optional even-parity bit per frame when SPG_PARITY_EN is defined.
`default_nettype none

module serial_pattern_gen #(
  parameter int PAT_W      = 8,
  parameter int LEN_W      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  input  logic [7:0]       repeat_cnt,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEND   = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
`ifdef SPG_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LEN_W-1:0] PAT_W_L  = LEN_W'(PAT_W);

  logic [2:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [7:0]       rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] len_eff, len_eff_m1, len_m1, idx_m1;
  logic [PAT_W-1:0] sh_start, sh_first, sh_next;

  // Out-of-range or zero length means a full-width frame.
  assign len_eff    = ((length == '0) || (length > PAT_W_L)) ? PAT_W_L : length;
  assign len_eff_m1 = len_eff - 1'b1;
  assign len_m1     = len_q - 1'b1;
  assign idx_m1     = idx_q - 1'b1;
  assign sh_start   = pattern >> len_eff_m1;
  assign sh_first   = pat_q >> len_m1;
  assign sh_next    = pat_q >> idx_m1;

`ifdef SPG_PARITY_EN
  logic parity;
  always_comb begin
    parity = 1'b0;
    for (int i = 0; i < PAT_W; i++) begin
      if (i < int'(len_q)) parity = parity ^ pat_q[i];
    end
  end
`endif

  always_comb begin
    logic frame_end;
    frame_end = 1'b0;
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    out_d     = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          pat_d   = pattern;
          len_d   = len_eff;
          rep_d   = repeat_cnt;
          idx_d   = len_eff_m1;
          state_d = S_SEND;
          out_d   = sh_start[0];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_SEND: begin
        if (idx_q != '0) begin
          idx_d   = idx_m1;
          out_d   = sh_next[0];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
`ifdef SPG_PARITY_EN
          state_d = S_PARITY;
          out_d   = parity;
          valid_d = 1'b1;
          busy_d  = 1'b1;
`else
          frame_end = 1'b1;
`endif
        end
      end
`ifdef SPG_PARITY_EN
      S_PARITY: frame_end = 1'b1;
`endif
      S_GAP: begin
        busy_d = 1'b1;
        if (gap_q == '0) begin
          state_d = S_SEND;
          idx_d   = len_m1;
          out_d   = sh_first[0];
          valid_d = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (frame_end) begin
      if (rep_q != 8'd0) begin
        rep_d  = rep_q - 8'd1;
        busy_d = 1'b1;
        if (GAP_CYCLES > 0) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = S_SEND;
          idx_d   = len_m1;
          out_d   = sh_first[0];
          valid_d = 1'b1;
        end
      end else begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
    end

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      out_d   = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ser_out   = out_q;
  assign ser_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: directed and random frames against a per-cycle expected stream.
`default_nettype none

module tb_serial_pattern_gen;

  localparam int PAT_W = 8;
  localparam int GAP   = 2;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [7:0] pattern;
  logic [3:0] length;
  logic [7:0] repeat_cnt;
  logic       ser_out, ser_valid, busy, done;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  serial_pattern_gen #(.PAT_W(8), .LEN_W(4), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern(pattern), .length(length), .repeat_cnt(repeat_cnt),
    .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  wire [3:0] obs = {ser_valid, ser_out, busy, done};

  // Expected {valid, out, busy, done} for every cycle after the start edge.
  function automatic void build_exp(input logic [7:0] pat, input int len, input int rep);
    int L;
    int ones;
    L = (len == 0 || len > PAT_W) ? PAT_W : len;
    exp_q.delete();
    for (int f = 0; f <= rep; f++) begin
      ones = 0;
      for (int b = L - 1; b >= 0; b--) begin
        ones += int'(pat[b]);
        exp_q.push_back({1'b1, pat[b], 1'b1, 1'b0});
      end
`ifdef SPG_PARITY_EN
      exp_q.push_back({1'b1, ones % 2 == 1, 1'b1, 1'b0});
`endif
      if (f < rep) for (int g = 0; g < GAP; g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
  endfunction

  task automatic send_frame(input logic [7:0] pat, input int len, input int rep,
                            input bit hold_start, input string tag);
    build_exp(pat, len, rep);
    pattern    = pat;
    length     = len[3:0];
    repeat_cnt = rep[7:0];
    start      = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    pattern    = 8'($urandom);
    length     = 4'($urandom);
    repeat_cnt = 8'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d: got vld/out/busy/done=%b expected %b", tag, i, obs, exp_q[i]);
      end
      if (i == exp_q.size() - 1) start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = '0; length = '0; repeat_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL reset: got %b expected 0000", obs);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_idle: got %b expected 0000", obs);
    end
  endtask

  task automatic test_basic();
    send_frame(8'h0B, 4, 0, 1'b0, "basic_0B");
    send_frame(8'h09, 4, 0, 1'b0, "basic_09");
    send_frame(8'h01, 1, 0, 1'b0, "single_bit");
  endtask

  task automatic test_repeat();
    send_frame(8'h0B, 4, 2, 1'b0, "repeat2");
  endtask

  task automatic test_length_clamp();
    send_frame(8'hA5, 0, 0, 1'b0, "len0");
    send_frame(8'hA5, 9, 0, 1'b0, "len9");
    send_frame(8'h3C, 15, 1, 1'b0, "len15");
  endtask

  task automatic test_abort();
    pattern = 8'h0B; length = 4'd4; repeat_cnt = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (obs !== 4'b1110) begin errors++; $display("FAIL abort_bit1: got %b expected 1110", obs); end
    @(posedge clk); #1;
    checks++;
    if (obs !== 4'b1010) begin errors++; $display("FAIL abort_bit2: got %b expected 1010", obs); end
    @(posedge clk); #1;
    checks++;
    if (obs !== 4'b1110) begin errors++; $display("FAIL abort_bit3: got %b expected 1110", obs); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL abort_idle: got %b expected 0000", obs); end
    send_frame(8'h0B, 4, 0, 1'b0, "after_abort");
    start = 1'b1; abort = 1'b1; pattern = 8'hFF; length = 4'd3;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL abort_beats_start: got %b expected 0000", obs); end
    @(posedge clk); #1;
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL abort_beats_start_2: got %b expected 0000", obs); end
  endtask

  task automatic test_async_reset();
    pattern = 8'hFF; length = 4'd8; repeat_cnt = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL async_reset: got %b expected 0000", obs); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL reset_no_resume: got %b expected 0000", obs); end
    send_frame(8'hC6, 5, 0, 1'b0, "after_reset");
  endtask

  task automatic test_start_held();
    send_frame(8'h5A, 6, 1, 1'b1, "start_held");
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      send_frame(8'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 1'b0, $sformatf("rand%0d", n));
    end
    send_frame(8'($urandom), 1, 255, 1'b0, "max_repeat");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat();
    test_length_clamp();
    test_abort();
    test_async_reset();
    test_start_held();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
